// File: rtl/uart_tx_sequencer.sv
// Drains a registered-output transmit FIFO into a UART transmitter one word at a time,
// with host-side pause (enable) and discard (flush) controls.
module uart_tx_sequencer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [WIDTH-1:0]     tx_data,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic                 idle
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_FLUSH
    } state_t;

    state_t                 state_reg,      state_next;
    logic [GAP_W-1:0]       gap_reg,        gap_next;
    logic [WIDTH-1:0]       tx_data_reg,    tx_data_next;
    logic [CNT_WIDTH-1:0]   sent_count_reg, sent_count_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            gap_reg        <= '0;
            tx_data_reg    <= '0;
            sent_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            gap_reg        <= gap_next;
            tx_data_reg    <= tx_data_next;
            sent_count_reg <= sent_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        gap_next        = gap_reg;
        tx_data_next    = tx_data_reg;
        sent_count_next = sent_count_reg;
        fifo_pop        = 1'b0;
        tx_start        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Flush wins over draining so a host discard is never raced by a send.
                if (flush && !fifo_empty) begin
                    state_next = S_FLUSH;
                end else if (enable && !fifo_empty && !tx_busy) begin
                    state_next = S_POP;
                end
            end
            S_POP: begin
                fifo_pop   = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                tx_data_next = fifo_data;
                state_next   = S_START;
            end
            S_START: begin
                tx_start   = 1'b1;
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    sent_count_next = sent_count_reg + 1'b1;
                    if (GAP_CYCLES > 0) begin
                        gap_next   = GAP_LOAD;
                        state_next = S_GAP;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            S_FLUSH: begin
                // Combinational pop so one word is discarded per cycle while data remains.
                fifo_pop = !fifo_empty;
                if (fifo_empty || !flush) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tx_data    = tx_data_reg;
    assign sent_count = sent_count_reg;
    assign idle       = (state_reg == S_IDLE);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: FIFO and transmitter models, a vector table of single-word
// sends, and directed sequences for gap, pause, flush, reset and counter wrap.
module tb_uart_tx_sequencer;

    localparam int WIDTH  = 8;
    localparam int GAP    = 2;
    localparam int CW     = 4;
    localparam int BUSY_T = 10;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             enable = 1'b0;
    logic             flush = 1'b0;
    logic             fifo_empty = 1'b1;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             tx_busy = 1'b0;
    logic             tx_start;
    logic [WIDTH-1:0] tx_data;
    logic [CW-1:0]    sent_count;
    logic             idle;

    logic             push_en = 1'b0;
    logic [WIDTH-1:0] push_val = '0;
    logic [WIDTH-1:0] fifo_q[$];
    int               busy_cnt = 0;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int starts = 0;
    int viol  = 0;
    int cyc   = 0;
    int fall_cyc = 0;
    bit fall_valid = 1'b0;
    logic busy_prev = 1'b0;
    logic [WIDTH-1:0] sent_log[$];
    int gaps[$];

    typedef struct {
        logic [WIDTH-1:0] word;
        int               exp_pop_lat;
        int               exp_start_lat;
        logic [CW-1:0]    exp_count;
    } vec_t;

    vec_t vecs[4];

    always #5 clock = ~clock;

    uart_tx_sequencer #(
        .WIDTH(WIDTH),
        .GAP_CYCLES(GAP),
        .CNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .enable(enable),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop),
        .fifo_data(fifo_data),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .sent_count(sent_count),
        .idle(idle)
    );

    // FIFO model with registered output.
    always @(posedge clock) begin
        if (fifo_pop && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        if (push_en) fifo_q.push_back(push_val);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Transmitter model: busy rises the cycle after start and stays high BUSY_T cycles.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            busy_cnt <= BUSY_T;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
    end

    always @(negedge clock) begin
        cyc++;
        if (!resetn) begin
            fall_valid = 1'b0;
            busy_prev  = 1'b0;
        end else begin
            if (busy_prev && !tx_busy) begin
                fall_cyc   = cyc;
                fall_valid = 1'b1;
            end
            if (fifo_pop) begin
                pops++;
                if (fifo_empty) begin
                    viol++;
                    $display("FAIL pop_while_empty: fifo_pop=1 with fifo_empty=1 at cycle %0d", cyc);
                end
                if (fall_valid) begin
                    gaps.push_back(cyc - fall_cyc);
                    fall_valid = 1'b0;
                end
            end
            if (tx_start) begin
                starts++;
                sent_log.push_back(tx_data);
                if (tx_busy) begin
                    viol++;
                    $display("FAIL start_while_busy: tx_start=1 with tx_busy=1 at cycle %0d", cyc);
                end
            end
            busy_prev = tx_busy;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        push_en  = 1'b1;
        push_val = v;
        tick();
        push_en  = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n = 0;
        while (starts < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_start_timeout"}, 32'(starts >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        tick();
        while (!(idle && !tx_busy) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0, l0, pop_lat, start_lat;
        logic [CW-1:0] c0;
        logic [WIDTH-1:0] start_data;

        vecs[0] = '{word: 8'hA5, exp_pop_lat: 1, exp_start_lat: 3, exp_count: 4'd1};
        vecs[1] = '{word: 8'h00, exp_pop_lat: 1, exp_start_lat: 3, exp_count: 4'd2};
        vecs[2] = '{word: 8'hFF, exp_pop_lat: 1, exp_start_lat: 3, exp_count: 4'd3};
        vecs[3] = '{word: 8'h5A, exp_pop_lat: 1, exp_start_lat: 3, exp_count: 4'd4};

        // Reset state
        tick();
        tick();
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_pop", 32'(fifo_pop), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_count", 32'(sent_count), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        resetn = 1'b1;
        tick();

        // Table: single words, latency from the first non-empty cycle
        for (int i = 0; i < 4; i++) begin
            enable    = 1'b1;
            p0        = pops;
            pop_lat   = -1;
            start_lat = -1;
            start_data = '0;
            push(vecs[i].word);
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (fifo_pop && pop_lat < 0) pop_lat = k;
                if (tx_start && start_lat < 0) begin
                    start_lat  = k;
                    start_data = tx_data;
                end
            end
            wait_idle(100, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_pop_lat", i), 32'(pop_lat), 32'(vecs[i].exp_pop_lat));
            check($sformatf("vec%0d_start_lat", i), 32'(start_lat), 32'(vecs[i].exp_start_lat));
            check($sformatf("vec%0d_txdata", i), 32'(start_data), 32'(vecs[i].word));
            check($sformatf("vec%0d_pops", i), 32'(pops - p0), 32'd1);
            check($sformatf("vec%0d_count", i), 32'(sent_count), 32'(vecs[i].exp_count));
        end

        // Back-to-back words with inter-word gap
        s0 = starts; l0 = sent_log.size(); c0 = sent_count;
        enable = 1'b1;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_starts(s0 + 3, 200, "b2b");
        wait_idle(100, "b2b");
        check("b2b_word0", 32'(sent_log[l0]), 32'h01);
        check("b2b_word1", 32'(sent_log[l0 + 1]), 32'h02);
        check("b2b_word2", 32'(sent_log[l0 + 2]), 32'h03);
        check("b2b_count", 32'(sent_count), 32'(4'(c0 + 4'd3)));
        check("b2b_gap1", 32'(gaps[gaps.size() - 2]), 32'(GAP + 2));
        check("b2b_gap2", 32'(gaps[gaps.size() - 1]), 32'(GAP + 2));

        // Pause during the first word
        s0 = starts; l0 = sent_log.size(); c0 = sent_count;
        enable = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_starts(s0 + 1, 50, "pause");
        enable = 1'b0;
        wait_idle(100, "pause");
        repeat (30) tick();
        check("pause_starts", 32'(starts - s0), 32'd1);
        check("pause_fifo_left", 32'(fifo_q.size()), 32'd2);
        check("pause_count", 32'(sent_count), 32'(4'(c0 + 4'd1)));
        enable = 1'b1;
        wait_starts(s0 + 3, 200, "resume");
        wait_idle(100, "resume");
        check("resume_word0", 32'(sent_log[l0]), 32'h11);
        check("resume_word1", 32'(sent_log[l0 + 1]), 32'h22);
        check("resume_word2", 32'(sent_log[l0 + 2]), 32'h33);
        check("resume_count", 32'(sent_count), 32'(4'(c0 + 4'd3)));

        // Flush discards queued words without sending
        enable = 1'b0;
        push(8'h44);
        push(8'h55);
        push(8'h66);
        push(8'h77);
        tick();
        p0 = pops; s0 = starts; c0 = sent_count;
        flush = 1'b1;
        repeat (6) tick();
        flush = 1'b0;
        repeat (5) tick();
        check("flush_pops", 32'(pops - p0), 32'd4);
        check("flush_fifo_empty", 32'(fifo_q.size()), 32'd0);
        check("flush_starts", 32'(starts - s0), 32'd0);
        check("flush_count", 32'(sent_count), 32'(c0));
        check("flush_idle", 32'(idle), 32'd1);

        // Async reset while waiting for the transmitter
        s0 = starts;
        enable = 1'b1;
        push(8'h88);
        wait_starts(s0 + 1, 50, "rstmid");
        repeat (4) tick();
        resetn = 1'b0;
        #1;
        check("rstmid_idle", 32'(idle), 32'd1);
        check("rstmid_start", 32'(tx_start), 32'd0);
        check("rstmid_pop", 32'(fifo_pop), 32'd0);
        check("rstmid_count", 32'(sent_count), 32'd0);
        check("rstmid_txdata", 32'(tx_data), 32'd0);
        tick();
        resetn = 1'b1;
        p0 = pops;
        repeat (20) tick();
        check("rstmid_no_pop", 32'(pops - p0), 32'd0);
        s0 = starts;
        push(8'h99);
        wait_starts(s0 + 1, 50, "rstmid_after");
        wait_idle(100, "rstmid_after");
        check("rstmid_after_word", 32'(sent_log[sent_log.size() - 1]), 32'h99);
        check("rstmid_after_count", 32'(sent_count), 32'd1);

        // Counter wrap: 17 words through a 4-bit counter
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("wrap_start_count", 32'(sent_count), 32'd0);
        s0 = starts; l0 = sent_log.size();
        enable = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i * 7 + 3));
        wait_starts(s0 + 17, 1000, "wrap");
        wait_idle(100, "wrap");
        check("wrap_count", 32'(sent_count), 32'd1);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("wrap_word%0d", i), 32'(sent_log[l0 + i]), 32'(8'(i * 7 + 3)));
        end

        check("protocol_violations", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
